// File: rtl/ac_pkg.sv
// ac_pkg: shared constants, walk-step encoding and FSM states for the autoconfig initiator
package ac_pkg;
   localparam logic [7:0] AC_BASE     = 8'hFF;
   localparam logic [1:0] Z3_TYPE     = 2'b10;
   localparam logic [7:0] OFF_TYPE_HI = 8'h00;
   localparam logic [7:0] OFF_TYPE_LO = 8'h02;
   localparam logic [7:0] OFF_PROD_HI = 8'h04;
   localparam logic [7:0] OFF_PROD_LO = 8'h06;
   localparam logic [7:0] OFF_MFG_0   = 8'h10;
   localparam logic [7:0] OFF_MFG_1   = 8'h12;
   localparam logic [7:0] OFF_MFG_2   = 8'h14;
   localparam logic [7:0] OFF_MFG_3   = 8'h16;
   localparam logic [7:0] OFF_BASE    = 8'h44;
   localparam logic [7:0] OFF_COMMIT  = 8'h48;
   localparam logic [7:0] OFF_SHUTUP  = 8'h4C;
   localparam logic [3:0] STEP_LAST_READ = 4'd7;
   localparam logic [3:0] STEP_BASE      = 4'd8;
   localparam logic [3:0] STEP_COMMIT    = 4'd9;
   localparam logic [3:0] STEP_SHUTUP    = 4'd10;
   typedef enum logic [3:0] {IDLE, CYC_START, CYC_WAIT, CYC_GAP, NEXT_REG, ASSIGN, SHUTUP, REPORT, FINISH} state_t;
   function automatic logic [7:0] step_offset(input logic [3:0] step);
      case (step)
         4'd0:        return OFF_TYPE_HI;
         4'd1:        return OFF_TYPE_LO;
         4'd2:        return OFF_PROD_HI;
         4'd3:        return OFF_PROD_LO;
         4'd4:        return OFF_MFG_0;
         4'd5:        return OFF_MFG_1;
         4'd6:        return OFF_MFG_2;
         4'd7:        return OFF_MFG_3;
         STEP_BASE:   return OFF_BASE;
         STEP_COMMIT: return OFF_COMMIT;
         default:     return OFF_SHUTUP;
      endcase
   endfunction
endpackage

// File: rtl/ac_configurator_if.sv
// ac_configurator_if: 68040-side autoconfig bus between initiator and responder chain
interface ac_configurator_if;
   logic [31:1] A;
   logic        nTS;
   logic        nTIP;
   logic        RnW;
   logic        AUTOCONFIG_SPACE;
   logic [3:0]  DOUT;
   logic [3:0]  DIN;
   logic        nAC_TA;
   modport master (output A, nTS, nTIP, RnW, AUTOCONFIG_SPACE, DOUT, input DIN, nAC_TA);
   modport slave  (input A, nTS, nTIP, RnW, AUTOCONFIG_SPACE, DOUT, output DIN, nAC_TA);
endinterface

// File: rtl/ac_bus_cycle.sv
// ac_bus_cycle: runs one autoconfig bus cycle (nTS/nTIP sequencing, TA sampling, timeout, DIN capture)
module ac_bus_cycle
   import ac_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic [7:0] offset,
   input  logic       rnw,
   input  logic [3:0] wdata,
   output logic       done,
   output logic       timeout,
   output logic [3:0] rdata,
   ac_configurator_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   // nTS low for the first cycle only; from then on TA is sampled until acknowledged or timed out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.A                <= '0;
         bus.nTS              <= 1'b1;
         bus.nTIP             <= 1'b1;
         bus.RnW              <= 1'b1;
         bus.AUTOCONFIG_SPACE <= 1'b0;
         bus.DOUT             <= '0;
         done                 <= 1'b0;
         timeout              <= 1'b0;
         rdata                <= '0;
         cnt                  <= '0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         if (bus.nTIP) begin
            if (go) begin
               bus.A                <= {AC_BASE, 16'h0, offset[7:1]};
               bus.RnW              <= rnw;
               bus.DOUT             <= wdata;
               bus.nTS              <= 1'b0;
               bus.nTIP             <= 1'b0;
               bus.AUTOCONFIG_SPACE <= 1'b1;
               cnt                  <= '0;
            end
         end else if (!bus.nTS) begin
            bus.nTS <= 1'b1;
         end else if (!bus.nAC_TA || cnt == CW'(TIMEOUT - 1)) begin
            bus.nTIP             <= 1'b1;
            bus.AUTOCONFIG_SPACE <= 1'b0;
            done                 <= !bus.nAC_TA;
            timeout              <= bus.nAC_TA;
            if (!bus.nAC_TA && bus.RnW) rdata <= bus.DIN;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ac_configurator.sv
// ac_configurator: walks the Zorro III autoconfig chain, reads IDs and assigns 256 MB base nibbles
module ac_configurator
   import ac_pkg::*;
#(
   parameter logic [3:0] BASE_FIRST = 4'h8,
   parameter logic [3:0] BASE_LAST  = 4'hB,
   parameter int         MAX_BOARDS = 8,
   parameter int         TIMEOUT    = 15
) (
   input  logic        CLK40,
   input  logic        RESET,
   input  logic        START,
   ac_configurator_if.master bus,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [3:0]  BOARD_COUNT,
   output logic        ID_VALID,
   output logic [7:0]  ID_TYPE,
   output logic [7:0]  ID_PRODUCT,
   output logic [15:0] ID_MFG,
   output logic [3:0]  ID_BASE
);
   state_t      state, nxt;
   logic [3:0]  step;
   logic [3:0]  processed;
   logic [4:0]  next_base;
   logic [31:0] sr;
   logic        tmo;
   logic        cyc_done, cyc_tmo;
   logic [3:0]  cyc_rdata;
   ac_bus_cycle #(.TIMEOUT(TIMEOUT)) u_cyc (
      .clk     (CLK40),
      .rst     (RESET),
      .go      (state == CYC_START),
      .offset  (step_offset(step)),
      .rnw     (step <= STEP_LAST_READ),
      .wdata   (step == STEP_BASE ? next_base[3:0] : 4'h0),
      .done    (cyc_done),
      .timeout (cyc_tmo),
      .rdata   (cyc_rdata),
      .bus     (bus)
   );
   // state register
   always_ff @(posedge CLK40 or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= nxt;
   end
   // sequence position decides where each finished bus cycle leads
   always_comb begin
      nxt = state;
      case (state)
         IDLE:                     nxt = START ? CYC_START : IDLE;
         CYC_START:                nxt = CYC_WAIT;
         CYC_WAIT:                 nxt = (cyc_done || cyc_tmo) ? CYC_GAP : CYC_WAIT;
         CYC_GAP:                  nxt = tmo ? FINISH :
                                         (step == 4'd1 && sr[7:6] != Z3_TYPE) ? FINISH :
                                         step == STEP_LAST_READ ? (next_base <= {1'b0, BASE_LAST} ? ASSIGN : SHUTUP) :
                                         step >= STEP_COMMIT ? REPORT : NEXT_REG;
         NEXT_REG, ASSIGN, SHUTUP: nxt = CYC_START;
         REPORT:                   nxt = processed == 4'(MAX_BOARDS - 1) ? FINISH : CYC_START;
         FINISH:                   nxt = IDLE;
         default:                  nxt = IDLE;
      endcase
   end
   // walk bookkeeping: ID assembly, base allocation, board counting and status flags
   always_ff @(posedge CLK40 or posedge RESET) begin
      if (RESET) begin
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
         BOARD_COUNT <= '0;
         ID_VALID    <= 1'b0;
         ID_TYPE     <= '0;
         ID_PRODUCT  <= '0;
         ID_MFG      <= '0;
         ID_BASE     <= '0;
         next_base   <= {1'b0, BASE_FIRST};
         step        <= '0;
         processed   <= '0;
         sr          <= '0;
         tmo         <= 1'b0;
      end else begin
         ID_VALID <= 1'b0;
         case (state)
            IDLE: if (START) begin
               BUSY        <= 1'b1;
               DONE        <= 1'b0;
               ERR         <= 1'b0;
               BOARD_COUNT <= '0;
               next_base   <= {1'b0, BASE_FIRST};
               step        <= '0;
               processed   <= '0;
            end
            CYC_WAIT: if (cyc_done || cyc_tmo) begin
               tmo <= cyc_tmo;
               if (cyc_done && step <= STEP_LAST_READ) sr <= {sr[27:0], step < 4'd2 ? cyc_rdata : ~cyc_rdata};
            end
            NEXT_REG: step <= step + 1'b1;
            ASSIGN:   step <= STEP_BASE;
            SHUTUP:   step <= STEP_SHUTUP;
            REPORT: begin
               ID_VALID   <= 1'b1;
               ID_TYPE    <= sr[31:24];
               ID_PRODUCT <= sr[23:16];
               ID_MFG     <= sr[15:0];
               ID_BASE    <= step == STEP_SHUTUP ? 4'h0 : next_base[3:0];
               if (step != STEP_SHUTUP) begin
                  BOARD_COUNT <= BOARD_COUNT + 1'b1;
                  next_base   <= next_base + 1'b1;
               end
               processed <= processed + 1'b1;
               step      <= '0;
            end
            FINISH: begin
               DONE <= 1'b1;
               BUSY <= 1'b0;
               ERR  <= tmo && step != 4'd0;
            end
            default: ;
         endcase
      end
   end
endmodule
